// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: request/blocking inputs, pipeline control outputs.
// master drives int_req/stall/is_branch/rti_done/pc_in; slave is int_ctrl.
interface int_ctrl_if;
    logic        int_req;
    logic        stall;
    logic        is_branch;
    logic        rti_done;
    logic [31:0] pc_in;
    logic [1:0]  pc_select;
    logic        flush;
    logic        push_pc;
    logic [31:0] saved_pc;
    logic        int_active;
    logic        int_pending;
    logic [7:0]  int_count;

    modport master (
        output int_req, stall, is_branch, rti_done, pc_in,
        input  pc_select, flush, push_pc, saved_pc,
        input  int_active, int_pending, int_count
    );

    modport slave (
        input  int_req, stall, is_branch, rti_done, pc_in,
        output pc_select, flush, push_pc, saved_pc,
        output int_active, int_pending, int_count
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt entry sequencer: edge-detect, wait, flush, push PC, vector, service.
// Ports: clk, rst (async active-low), bus (int_ctrl_if.slave).
module int_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    int_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FLUSH,
        ST_PUSH,
        ST_VECTOR,
        ST_SERVICE
    } state_e;

    localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic        int_req_q, int_req_d;
    logic        armed_q, armed_d;
    logic        pending_q, pending_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [7:0]  count_q, count_d;
    logic        req_edge;
    logic        accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            int_req_q  <= 1'b0;
            armed_q    <= 1'b0;
            pending_q  <= 1'b0;
            cnt_q      <= 3'd0;
            saved_pc_q <= 32'h0;
            count_q    <= 8'h0;
        end else begin
            state_q    <= state_d;
            int_req_q  <= int_req_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            saved_pc_q <= saved_pc_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        int_req_d  = bus.int_req;
        // A line held high across reset release is not a new request:
        // edges are only honoured once the line has been seen low.
        armed_d    = armed_q | ~bus.int_req;
        req_edge   = bus.int_req & ~int_req_q & armed_q;
        accept     = (state_q == ST_WAIT) & ~bus.stall & ~bus.is_branch;
        // Set beats clear when a new edge lands on the accept cycle.
        pending_d  = req_edge | (pending_q & ~accept);
        state_d    = state_q;
        cnt_d      = cnt_q;
        saved_pc_d = saved_pc_q;
        count_d    = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (accept) begin
                    state_d    = ST_FLUSH;
                    saved_pc_d = bus.pc_in;
                    cnt_d      = CNT_INIT;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 3'd0) state_d = ST_PUSH;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_PUSH: begin
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_d = ST_SERVICE;
                if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end
            ST_SERVICE: begin
                if (bus.rti_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.flush       = (state_q == ST_FLUSH);
    assign bus.push_pc     = (state_q == ST_PUSH);
    assign bus.pc_select   = (state_q == ST_VECTOR) ? 2'b10 : 2'b00;
    assign bus.int_active  = (state_q == ST_SERVICE);
    assign bus.int_pending = pending_q;
    assign bus.saved_pc    = saved_pc_q;
    assign bus.int_count   = count_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with DRAIN_CYCLES = 3.
// Drives the interface directly and checks outputs 1ns after each edge.
module tb_int_ctrl;
    localparam int DRAIN = 3;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    int_ctrl_if bus ();

    int_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
    endtask

    task automatic rti();
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
    endtask

    // Precondition: in WAIT and unblocked on the next edge.
    task automatic flow(input logic [31:0] exp_pc, input logic [7:0] exp_cnt);
        for (int i = 0; i < DRAIN; i++) begin
            tick();
            chk("flush", 32'(bus.flush), 32'd1);
            chk("fl_push", 32'(bus.push_pc), 32'd0);
            if (i == 0) chk("saved_pc", bus.saved_pc, exp_pc);
        end
        tick();
        chk("push", 32'(bus.push_pc), 32'd1);
        chk("push_fl", 32'(bus.flush), 32'd0);
        tick();
        chk("vec_sel", 32'(bus.pc_select), 32'd2);
        chk("vec_push", 32'(bus.push_pc), 32'd0);
        chk("vec_cnt", 32'(bus.int_count), 32'(exp_cnt - 8'd1));
        tick();
        chk("svc_act", 32'(bus.int_active), 32'd1);
        chk("svc_sel", 32'(bus.pc_select), 32'd0);
        chk("svc_cnt", 32'(bus.int_count), 32'(exp_cnt));
    endtask

    task automatic quick_service();
        pulse();
        repeat (DRAIN + 4) tick();
        rti();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.int_req   = 1'b0;
        bus.stall     = 1'b0;
        bus.is_branch = 1'b0;
        bus.rti_done  = 1'b0;
        bus.pc_in     = 32'h0;
        #3 rst = 1'b0;
        tick();
        tick();
        chk("rst_sel", 32'(bus.pc_select), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_push", 32'(bus.push_pc), 32'd0);
        chk("rst_spc", bus.saved_pc, 32'h0);
        chk("rst_act", 32'(bus.int_active), 32'd0);
        chk("rst_pend", 32'(bus.int_pending), 32'd0);
        chk("rst_cnt", 32'(bus.int_count), 32'd0);
        rst = 1'b1;
        tick();
        tick();

        // basic
        bus.pc_in = 32'h0000_0040;
        pulse();
        chk("b_pend", 32'(bus.int_pending), 32'd1);
        tick();
        chk("b_wait_fl", 32'(bus.flush), 32'd0);
        flow(32'h40, 8'd1);
        chk("b_pend0", 32'(bus.int_pending), 32'd0);
        bus.pc_in = 32'h0000_0099;
        repeat (3) tick();
        chk("b_act", 32'(bus.int_active), 32'd1);
        chk("b_hold", bus.saved_pc, 32'h40);
        rti();
        chk("b_rti", 32'(bus.int_active), 32'd0);

        // blocking: stall 5 cycles, then branch 2 cycles
        bus.stall = 1'b1;
        pulse();
        tick();
        bus.rti_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_fl", 32'(bus.flush), 32'd0);
            chk("stall_act", 32'(bus.int_active), 32'd0);
        end
        bus.rti_done  = 1'b0;
        bus.stall     = 1'b0;
        bus.is_branch = 1'b1;
        bus.pc_in     = 32'h0000_0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("br_fl", 32'(bus.flush), 32'd0);
            chk("br_pend", 32'(bus.int_pending), 32'd1);
        end
        chk("br_spc", bus.saved_pc, 32'h40);
        bus.is_branch = 1'b0;
        bus.pc_in     = 32'h0000_0200;
        flow(32'h200, 8'd2);

        // nesting: edge during service only pends
        bus.pc_in = 32'h0000_0300;
        pulse();
        chk("n_pend", 32'(bus.int_pending), 32'd1);
        chk("n_act", 32'(bus.int_active), 32'd1);
        tick();
        chk("n_act2", 32'(bus.int_active), 32'd1);
        rti();
        chk("n_idle", 32'(bus.int_active), 32'd0);
        chk("n_pend2", 32'(bus.int_pending), 32'd1);
        tick();
        chk("n_wait", 32'(bus.flush), 32'd0);
        flow(32'h300, 8'd3);
        rti();

        // collision: new edge on the accept cycle
        bus.pc_in = 32'h0000_0400;
        pulse();
        tick();
        bus.int_req = 1'b1;
        flow(32'h400, 8'd4);
        chk("c_pend", 32'(bus.int_pending), 32'd1);
        bus.int_req = 1'b0;
        bus.pc_in   = 32'h0000_0500;
        rti();
        chk("c_pend2", 32'(bus.int_pending), 32'd1);
        tick();
        flow(32'h500, 8'd5);
        chk("c_pend3", 32'(bus.int_pending), 32'd0);
        rti();

        // reset in FLUSH cycle 2, request line held high
        pulse();
        tick();
        tick();
        tick();
        chk("r_fl2", 32'(bus.flush), 32'd1);
        bus.int_req = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("r_flush", 32'(bus.flush), 32'd0);
        chk("r_push", 32'(bus.push_pc), 32'd0);
        chk("r_sel", 32'(bus.pc_select), 32'd0);
        chk("r_pend", 32'(bus.int_pending), 32'd0);
        chk("r_cnt", 32'(bus.int_count), 32'd0);
        chk("r_spc", bus.saved_pc, 32'h0);
        repeat (2) tick();
        #2 rst = 1'b1;
        repeat (6) tick();
        chk("r_npend", 32'(bus.int_pending), 32'd0);
        chk("r_nfl", 32'(bus.flush), 32'd0);
        chk("r_nact", 32'(bus.int_active), 32'd0);
        chk("r_ncnt", 32'(bus.int_count), 32'd0);
        bus.int_req = 1'b0;
        tick();
        tick();

        // saturation
        for (int i = 1; i <= 256; i++) begin
            quick_service();
            if (i == 254) chk("sat_254", 32'(bus.int_count), 32'd254);
            if (i == 255) chk("sat_255", 32'(bus.int_count), 32'd255);
        end
        chk("sat_256", 32'(bus.int_count), 32'd255);
        chk("sat_idle", 32'(bus.int_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, number of flush cycles needed to empty the fetch-to-memory pipeline (legal range 1..7).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
REQ-004 SHALL have port int_req  input  1  external interrupt line; only a 0->1 transition is a request.
REQ-005 SHALL have port stall  input  1  pipeline stall; blocks interrupt acceptance.
REQ-006 SHALL have port is_branch  input  1  instruction now in fetch is a control transfer; blocks acceptance.
REQ-007 SHALL have port rti_done  input  1  one-cycle pulse when return-from-interrupt retires.
REQ-008 SHALL have port pc_in  input  32  current fetch PC.
REQ-009 SHALL have port pc_select  output  2  fetch PC mux select: 2'b00 sequential, 2'b10 vector to IVT.
REQ-010 SHALL have port flush  output  1  squash all buffer contents upstream of writeback.
REQ-011 SHALL have port push_pc  output  1  memory stage pushes saved_pc as one 32-bit stack write.
REQ-012 SHALL have port saved_pc  output  32  PC captured at acceptance.
REQ-013 SHALL have port int_active  output  1  handler in service.
REQ-014 SHALL have port int_pending  output  1  request latched, not yet accepted.
REQ-015 SHALL have port int_count  output  8  serviced-interrupt counter.

Function
REQ-016 SHALL register int_req into int_req_q each cycle; edge = int_req & ~int_req_q.
REQ-017 SHALL set int_pending on the edge following a detected rising edge; only one pending request is held, additional edges while pending are dropped.
REQ-018 SHALL implement states IDLE, WAIT, FLUSH, PUSH, VECTOR, SERVICE.
REQ-019 IDLE: if int_pending=1 -> WAIT next cycle; else stay.
REQ-020 WAIT: if stall=0 and is_branch=0 -> FLUSH, saved_pc<=pc_in, int_pending cleared; else stay, saved_pc unchanged.
REQ-021 If a new rising edge coincides with the WAIT->FLUSH clear, set SHALL win: int_pending stays 1 after the edge.
REQ-022 FLUSH: flush=1 for exactly DRAIN_CYCLES consecutive cycles using a 3-bit down-counter, then -> PUSH; stall is ignored once in FLUSH.
REQ-023 PUSH: push_pc=1 for exactly one cycle, then -> VECTOR.
REQ-024 VECTOR: pc_select=2'b10 for exactly one cycle, then -> SERVICE; int_count increments on leaving VECTOR, saturating at 8'hFF.
REQ-025 SERVICE: int_active=1; no nesting; new edges only set int_pending; rti_done=1 -> IDLE next cycle.
REQ-026 rti_done in any state other than SERVICE SHALL be ignored.
REQ-027 pc_select SHALL be 2'b00, flush 0, push_pc 0 in every state except where REQ-022..024 assert them; all outputs are Moore (state/register only, no input-to-output combinational path).
REQ-028 Acceptance latency: edge sampled at cycle N -> pending at N+1 -> WAIT at N+2 -> first flush cycle at N+3 when unblocked.
REQ-029 saved_pc SHALL hold its value from acceptance until the next acceptance.

Reset
REQ-030 On rst=0: state=IDLE, int_req_q=0, int_pending=0, counter=0, saved_pc=32'h0, int_count=8'h0, pc_select=2'b00, flush=0, push_pc=0, int_active=0.
REQ-031 Reset asserted mid-sequence (any state) SHALL abort it; after release no pending request survives and int_req held high produces no edge until it returns to 0 and rises again.

Verification
REQ-032 Basic: pulse int_req, pc_in=32'h0000_0040, stall=0 -> flush high 3 cycles, push_pc 1 cycle, pc_select=2'b10 1 cycle, saved_pc=32'h40, int_count=1, int_active=1 until rti_done.
REQ-033 Blocking: stall=1 for 5 cycles then is_branch=1 for 2 cycles in WAIT -> no flush until both 0; saved_pc equals pc_in of the release cycle.
REQ-034 Nesting: second edge during SERVICE -> int_pending=1, int_active stays 1; after rti_done, IDLE->WAIT and full sequence repeats, int_count=2.
REQ-035 Collision: rising edge in the same cycle WAIT->FLUSH -> int_pending=1 afterwards, second service follows first.
REQ-036 Reset: rst=0 during FLUSH cycle 2 -> all outputs immediately at reset values; int_req held high through release -> no new service.
REQ-037 Saturation: 256 serviced interrupts -> int_count stays 8'hFF.
